mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one memory port between the processor's instruction-fetch requester (port 0, `imem`) and data requester (port 1, `dmem`). Selects a requester with round-robin priority and forwards its request using val/rdy handshaking. Allows one outstanding transaction at a time and routes the response back to the requester that issued it. Sits between the pipelined core's F/M memory interfaces and the single-ported memory.

## Interface

- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `imemreq_val`  in  1  fetch request valid.
- `imemreq_rdy`  out  1  fetch request accepted this cycle.
- `imemreq_addr`  in  ADDR_W  fetch address. Fetches are always reads.
- `imemresp_val`  out  1  fetch response valid, one cycle.
- `imemresp_rdata`  out  DATA_W  fetch read data.
- `dmemreq_val`  in  1  data request valid.
- `dmemreq_rdy`  out  1  data request accepted this cycle.
- `dmemreq_type`  in  1  0 = read, 1 = write.
- `dmemreq_addr`  in  ADDR_W  data address.
- `dmemreq_wdata`  in  DATA_W  write data.
- `dmemresp_val`  out  1  data response valid, one cycle.
- `dmemresp_rdata`  out  DATA_W  data read data (write response: don't care).
- `memreq_val`  out  1  shared port request valid.
- `memreq_rdy`  in  1  memory accepts request.
- `memreq_type`  out  1  0 = read, 1 = write.
- `memreq_addr`  out  ADDR_W  address.
- `memreq_wdata`  out  DATA_W  write data.
- `memresp_val`  in  1  memory response valid.
- `memresp_rdata`  in  DATA_W  memory read data.
- `err`  out  1  sticky protocol error flag.

## Operation

- State machine states:
  - IDLE: no request held.
  - REQ: a grant is latched and the request is being presented.
  - WAIT: the request was accepted and a response is outstanding.
- Registers:
  - `state`.
  - `owner` (0 = imem, 1 = dmem).
  - `prio` (port that wins a tie).
  - `err`.
- IDLE:
  - If exactly one `*req_val` is high, that port wins.
  - If both are high, `prio` wins.
  - The winner's fields drive `memreq_*` combinationally, with `memreq_val`=1.
  - If `memreq_rdy`=1 the same cycle: winner's `*req_rdy`=1, `owner`←winner, go to WAIT.
  - Otherwise: `owner`←winner, go to REQ.
- REQ:
  - Drive the `owner` port's fields with `memreq_val`=1. The grant does not change, even if the other port raises val.
  - On `memreq_rdy`: that port's `*req_rdy`=1, go to WAIT.
  - Requesters hold val and payload stable until rdy. Behaviour on a dropped val is undefined.
- WAIT:
  - `memreq_val`=0 and both `*req_rdy`=0.
  - On `memresp_val`: pulse the `owner` port's `*resp_val` with `*resp_rdata`=`memresp_rdata`, go to IDLE.
- imem requests always present `memreq_type`=0 and `memreq_wdata`=0.
- `prio` update: on every acceptance (`*req_rdy` pulse), `prio` ← the non-granted port.
- `err`: set when `memresp_val`=1 in IDLE or REQ (unsolicited response). That response is dropped and no `*resp_val` fires. `err` clears only on reset.
- `memreq_*` outputs when `memreq_val`=0: addr/wdata/type are driven 0.

## Timing

- Reset (asynchronous, `rst`=0): state=IDLE, owner=0, prio=1 (dmem first), err=0.
- While in reset, all `*_val` and `*_rdy` outputs are 0 and all data outputs are 0.
- Reset mid-transaction: the outstanding response is abandoned. A late `memresp_val` after reset sets `err`.
- Minimum cycles per transaction with `memreq_rdy` tied 1 and 1-cycle memory: 2 cycles (accept in IDLE, response in WAIT). Back-to-back issue is possible from the cycle after the response.
- No request is issued in the cycle a response returns; return to IDLE takes one edge.
- Response to requester: 0 added latency (`*resp_val` is combinational from `memresp_val` in WAIT).
- Request to memory: 0 added latency (combinational mux from the selected requester in IDLE/REQ).
- Simultaneous `imemreq_val` and `dmemreq_val` in IDLE: `prio` decides.
- Under continuous contention, grants strictly alternate.

## Test plan

- Reset, then `dmemreq_val` only: addr=0x100, type=1, wdata=0xDEADBEEF, `memreq_rdy`=1.
  - Required: same cycle `memreq_val`=1, addr=0x100, wdata=0xDEADBEEF, `dmemreq_rdy`=1.
  - Next cycle, memory returns `memresp_val`: `dmemresp_val`=1 and `imemresp_val`=0.
- Both ports valid continuously (imem addr=0x0, dmem addr=0x200), `memreq_rdy`=1, 1-cycle memory.
  - Required: grant order dmem, imem, dmem, imem.
  - Each response routes to the correct port with the returned rdata.
- imem valid, `memreq_rdy`=0 for 3 cycles, dmem raises val in cycle 2.
  - Required: `memreq_addr` stays imem's for all 3 cycles.
  - `dmemreq_rdy` stays 0.
  - imem is accepted when rdy rises.
- imem read of 0x40 accepted, memory response delayed 5 cycles with rdata=0x12345678.
  - Required: no `memreq_val` during the wait.
  - `imemresp_rdata`=0x12345678 on the response cycle.
- `memresp_val` pulsed while IDLE.
  - Required: `err`=1 from the next cycle, no `*resp_val`.
  - `err` stays 1 until `rst`=0.
- Assert `rst`=0 asynchronously while in WAIT.
  - Required: outputs go to reset values immediately.
  - After release, a new dmem request is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and data (port 1), one transaction in flight.
// Zero added latency both ways; memreq_rdy low holds the latched grant, and no request issues while a response is outstanding.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              imemreq_val,
    output logic              imemreq_rdy,
    input  logic [ADDR_W-1:0] imemreq_addr,
    output logic              imemresp_val,
    output logic [DATA_W-1:0] imemresp_rdata,

    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    input  logic              dmemreq_type,
    input  logic [ADDR_W-1:0] dmemreq_addr,
    input  logic [DATA_W-1:0] dmemreq_wdata,
    output logic              dmemresp_val,
    output logic [DATA_W-1:0] dmemresp_rdata,

    output logic              memreq_val,
    input  logic              memreq_rdy,
    output logic              memreq_type,
    output logic [ADDR_W-1:0] memreq_addr,
    output logic [DATA_W-1:0] memreq_wdata,
    input  logic              memresp_val,
    input  logic [DATA_W-1:0] memresp_rdata,

    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q,  prio_d;
    logic   err_q,   err_d;

    logic   req_any;
    logic   sel;
    logic   accept;
    logic   resp_hit;
    logic   gnt_vld;

    // Next-state logic is kept free of rst so the reset net only reaches flop reset pins.
    always_comb begin
        req_any = 1'b0;
        sel     = owner_q;
        case (state_q)
            IDLE: begin
                req_any = imemreq_val | dmemreq_val;
                sel     = (imemreq_val & dmemreq_val) ? prio_q : dmemreq_val;
            end
            REQ: begin
                req_any = 1'b1;
                sel     = owner_q;
            end
            default: begin
                req_any = 1'b0;
                sel     = owner_q;
            end
        endcase
    end

    assign accept   = req_any & memreq_rdy;
    assign resp_hit = (state_q == WAIT) & memresp_val;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d = sel;
                    state_d = accept ? WAIT : REQ;
                end
                if (accept) prio_d = ~sel;
                if (memresp_val) err_d = 1'b1;
            end
            REQ: begin
                if (memreq_rdy) begin
                    state_d = WAIT;
                    prio_d  = ~owner_q;
                end
                if (memresp_val) err_d = 1'b1;
            end
            WAIT: begin
                if (memresp_val) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            err_q   <= err_d;
        end
    end

    // Outputs are qualified with rst so everything reads zero while reset is held.
    assign gnt_vld      = req_any & rst;
    assign memreq_val   = gnt_vld;
    assign memreq_type  = gnt_vld & sel & dmemreq_type;
    assign memreq_addr  = !gnt_vld ? '0 : (sel ? dmemreq_addr : imemreq_addr);
    assign memreq_wdata = (gnt_vld & sel) ? dmemreq_wdata : '0;

    assign imemreq_rdy  = accept & rst & ~sel;
    assign dmemreq_rdy  = accept & rst &  sel;

    assign imemresp_val   = resp_hit & rst & ~owner_q;
    assign dmemresp_val   = resp_hit & rst &  owner_q;
    assign imemresp_rdata = imemresp_val ? memresp_rdata : '0;
    assign dmemresp_rdata = dmemresp_val ? memresp_rdata : '0;

    assign err = err_q & rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued as requests are driven and checked on return.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        imemreq_val, imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_rdata;
    logic        dmemreq_val, dmemreq_rdy, dmemreq_type;
    logic [31:0] dmemreq_addr, dmemreq_wdata;
    logic        dmemresp_val;
    logic [31:0] dmemresp_rdata;
    logic        memreq_val, memreq_rdy, memreq_type;
    logic [31:0] memreq_addr, memreq_wdata;
    logic        memresp_val;
    logic [31:0] memresp_rdata;
    logic        err;

    logic        mem_auto;
    logic        auto_val, man_val;
    logic [31:0] auto_rdata, man_rdata;
    logic        pending;
    logic [31:0] pend_addr;

    logic [32:0] exp_q[$];
    int          n_run;
    int          n_fail;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
        .imemresp_val(imemresp_val), .imemresp_rdata(imemresp_rdata),
        .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
        .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
        .dmemresp_val(dmemresp_val), .dmemresp_rdata(dmemresp_rdata),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
        .memresp_val(memresp_val), .memresp_rdata(memresp_rdata),
        .err(err)
    );

    assign memresp_val   = auto_val | man_val;
    assign memresp_rdata = auto_val ? auto_rdata : man_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle memory: answers the cycle after an accept with ~addr.
    initial begin
        pending   = 1'b0;
        pend_addr = '0;
        auto_val  = 1'b0;
        auto_rdata = '0;
    end
    always begin
        @(posedge clk);
        #1;
        auto_val   = pending;
        auto_rdata = ~pend_addr;
        pending    = 1'b0;
        @(negedge clk);
        if (mem_auto && memreq_val && memreq_rdy) begin
            pending   = 1'b1;
            pend_addr = memreq_addr;
        end
    end

    always @(negedge clk) begin
        if (rst && (imemresp_val || dmemresp_val)) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_both", {63'd0, imemresp_val & dmemresp_val}, 0);
                chk("resp_port", {63'd0, dmemresp_val}, {63'd0, e[32]});
                chk("resp_data", e[32] ? dmemresp_rdata : imemresp_rdata, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_run = 0; n_fail = 0;
        rst = 1'b0;
        mem_auto = 1'b0; man_val = 1'b0; man_rdata = '0;
        imemreq_val = 1'b1; imemreq_addr = 32'h44;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h88; dmemreq_wdata = 32'h99;
        memreq_rdy = 1'b1;
        #3;
        man_val = 1'b1; man_rdata = 32'hFFFF;
        #1;
        chk("rst_memreq_val", memreq_val, 0);
        chk("rst_irdy", imemreq_rdy, 0);
        chk("rst_drdy", dmemreq_rdy, 0);
        chk("rst_addr", memreq_addr, 0);
        chk("rst_wdata", memreq_wdata, 0);
        chk("rst_type", memreq_type, 0);
        chk("rst_resp", {62'd0, imemresp_val, dmemresp_val}, 0);
        chk("rst_rdata", {imemresp_rdata, dmemresp_rdata}, 0);
        chk("rst_err", err, 0);
        man_val = 1'b0;
        imemreq_val = 1'b0; dmemreq_val = 1'b0;
        step(); step();
        rst = 1'b1;

        // Single dmem write accepted in the same cycle.
        mem_auto = 1'b1;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h100; dmemreq_wdata = 32'hDEADBEEF;
        exp_q.push_back({1'b1, ~32'h100});
        @(negedge clk);
        chk("t1_val", memreq_val, 1);
        chk("t1_addr", memreq_addr, 32'h100);
        chk("t1_wdata", memreq_wdata, 32'hDEADBEEF);
        chk("t1_type", memreq_type, 1);
        chk("t1_drdy", dmemreq_rdy, 1);
        chk("t1_irdy", imemreq_rdy, 0);
        step();
        dmemreq_val = 1'b0;
        @(negedge clk);
        chk("t1_dresp", dmemresp_val, 1);
        chk("t1_iresp", imemresp_val, 0);
        chk("t1_wait_val", memreq_val, 0);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;

        // Continuous contention from reset: dmem, imem, dmem, imem.
        imemreq_val = 1'b1; imemreq_addr = 32'h0;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h200; dmemreq_type = 1'b0; dmemreq_wdata = 32'h0;
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) exp_q.push_back({1'b1, ~32'h200});
            else            exp_q.push_back({1'b0, ~32'h0});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                logic exp_d;
                exp_d = (k % 4 == 0);
                chk("t2_dgnt", dmemreq_rdy, {63'd0, exp_d});
                chk("t2_ignt", imemreq_rdy, {63'd0, !exp_d});
                chk("t2_addr", memreq_addr, exp_d ? 32'h200 : 32'h0);
            end else begin
                chk("t2_wait_val", memreq_val, 0);
            end
            step();
            if (k == 7) begin
                imemreq_val = 1'b0; dmemreq_val = 1'b0;
            end
        end

        // imem grant held through backpressure while dmem arrives.
        memreq_rdy = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h80;
        exp_q.push_back({1'b0, ~32'h80});
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                dmemreq_val = 1'b1; dmemreq_addr = 32'h300;
            end
            @(negedge clk);
            chk("t3_addr", memreq_addr, 32'h80);
            chk("t3_irdy", imemreq_rdy, 0);
            chk("t3_drdy", dmemreq_rdy, 0);
            step();
        end
        memreq_rdy = 1'b1;
        @(negedge clk);
        chk("t3_accept", imemreq_rdy, 1);
        chk("t3_drdy_acc", dmemreq_rdy, 0);
        chk("t3_addr_acc", memreq_addr, 32'h80);
        step();
        imemreq_val = 1'b0; dmemreq_val = 1'b0;
        step();
        step();
        mem_auto = 1'b0;

        // Slow memory: nothing issues while the response is outstanding.
        imemreq_val = 1'b1; imemreq_addr = 32'h40;
        exp_q.push_back({1'b0, 32'h12345678});
        @(negedge clk);
        chk("t4_accept", imemreq_rdy, 1);
        step();
        imemreq_val = 1'b0;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h400;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_no_req", memreq_val, 0);
            chk("t4_drdy", dmemreq_rdy, 0);
            step();
        end
        dmemreq_val = 1'b0;
        man_val = 1'b1; man_rdata = 32'h12345678;
        @(negedge clk);
        chk("t4_iresp", imemresp_val, 1);
        chk("t4_rdata", imemresp_rdata, 32'h12345678);
        step();
        man_val = 1'b0;

        // Unsolicited response in IDLE.
        step();
        man_val = 1'b1; man_rdata = 32'hBAD;
        @(negedge clk);
        chk("t5_noresp", {62'd0, imemresp_val, dmemresp_val}, 0);
        chk("t5_err_before", err, 0);
        step();
        man_val = 1'b0;
        @(negedge clk);
        chk("t5_err_set", err, 1);
        step(); step();
        @(negedge clk);
        chk("t5_err_sticky", err, 1);
        step();

        // Asynchronous reset while a response is outstanding.
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h500; dmemreq_wdata = 32'h55;
        @(negedge clk);
        chk("t6_accept", dmemreq_rdy, 1);
        step();
        dmemreq_val = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h700;
        man_val = 1'b1; man_rdata = 32'h77;
        #1;
        chk("t6_rst_err", err, 0);
        chk("t6_rst_val", memreq_val, 0);
        chk("t6_rst_irdy", imemreq_rdy, 0);
        chk("t6_rst_addr", memreq_addr, 0);
        chk("t6_rst_dresp", dmemresp_val, 0);
        chk("t6_rst_rdata", dmemresp_rdata, 0);
        step();
        rst = 1'b1;
        imemreq_val = 1'b0;
        @(negedge clk);
        chk("t6_late_noresp", {62'd0, imemresp_val, dmemresp_val}, 0);
        chk("t6_err_pre", err, 0);
        step();
        man_val = 1'b0;
        @(negedge clk);
        chk("t6_late_err", err, 1);
        step();
        mem_auto = 1'b1;
        imemreq_val = 1'b1; imemreq_addr = 32'h700;
        dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h600;
        exp_q.push_back({1'b1, ~32'h600});
        @(negedge clk);
        chk("t6_dgnt_first", dmemreq_rdy, 1);
        chk("t6_ignt", imemreq_rdy, 0);
        step();
        imemreq_val = 1'b0; dmemreq_val = 1'b0;
        step(); step();

        chk("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
